// File: rtl/muldiv_pkg.sv
// Shared opcode encodings, FSM state type and operand-class helpers for the
// iterative RV32M multiply/divide engine.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // MUL is treated as unsigned: its low word does not depend on operand signs.
  function automatic logic is_signed_rs1(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_rs2(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              div_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] cand;
  logic [XLEN:0] diff;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    acc_o   = '0;
    q_bit_o = 1'b0;
    sum     = '0;
    cand    = '0;
    diff    = '0;
    if (div_i) begin
      // Upper word is the partial remainder, lower word shifts the dividend out MSB-first
      // and leaves a free LSB for the quotient bit, which the caller merges in.
      cand    = acc_i[2*XLEN-1:XLEN-1];
      diff    = cand - {1'b0, opnd_i};
      q_bit_o = ~diff[XLEN];
      acc_o   = {(q_bit_o ? diff[XLEN-1:0] : cand[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
    end else begin
      // Lower word holds the multiplier, consumed LSB-first.
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (acc_i[0] ? opnd_i : '0)};
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: IDLE -> CALC (XLEN steps) -> FIN,
// with divide special cases short-circuiting straight to FIN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e                state_q;
  logic [2:0]            funct3_q;
  logic                  s1_q, s2_q;
  logic [XLEN-1:0]       opnd_q;
  logic [2*XLEN-1:0]     acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [XLEN-1:0]       result_q;
  logic                  done_q;

  logic [2*XLEN-1:0]     step_acc;
  logic                  step_q_bit;
  logic [2*XLEN-1:0]     acc_d;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       quot, rem;
  logic [XLEN-1:0]       result_d;

  logic                  in_div, in_s1, in_s2, div_zero, div_ovf;
  logic [XLEN-1:0]       mag1, mag2, special_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .div_i   (is_div(funct3_q)),
    .acc_o   (step_acc),
    .q_bit_o (step_q_bit)
  );

  assign acc_d = step_acc | {{(2*XLEN-1){1'b0}}, step_q_bit};

  // Launch-time decode: operand signs, magnitudes and the divide special cases.
  always_comb begin
    in_div      = is_div(funct3_i);
    in_s1       = is_signed_rs1(funct3_i) & data1_i[XLEN-1];
    in_s2       = is_signed_rs2(funct3_i) & data2_i[XLEN-1];
    mag1        = in_s1 ? -data1_i : data1_i;
    mag2        = in_s2 ? -data2_i : data2_i;
    div_zero    = in_div && (data2_i == '0);
    div_ovf     = in_div && is_signed_rs1(funct3_i) && (data1_i == INT_MIN) && (data2_i == '1);
    special_res = '0;
    if (div_zero)     special_res = funct3_i[1] ? data1_i : '1;
    else if (div_ovf) special_res = funct3_i[1] ? '0 : INT_MIN;
  end

  // Sign correction applied to the accumulator value after the final step.
  always_comb begin
    prod     = (s1_q ^ s2_q) ? -acc_d : acc_d;
    quot     = (s1_q ^ s2_q) ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
    rem      = s1_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
    result_d = '0;
    case (funct3_q)
      F3_MUL:                       result_d = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result_d = quot;
      F3_REM, F3_REMU:              result_d = rem;
      default:                      result_d = '0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      funct3_q <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i && !kill_i) begin
            funct3_q <= funct3_i;
            s1_q     <= in_s1;
            s2_q     <= in_s2;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= ST_FIN;
            end else begin
              // Divide: low word is the dividend. Multiply: low word is the multiplier.
              acc_q   <= {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
              opnd_q  <= in_div ? mag2 : mag1;
              cnt_q   <= CNT_W'(XLEN - 1);
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill_i) begin
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              result_q <= result_d;
              done_q   <= 1'b1;
              state_q  <= ST_FIN;
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q & ~kill_i;

endmodule
